// File: rtl/packed_bus_pkg.sv
// ---------------------------------------------------------------------------
// packed_bus_pkg
//
// Shared definitions for both ends of the packed bus. The transmit side
// (packer) and the receive side (packed_word_unpacker) agree on the field
// layout through this package: a packed word is {hi, lo}, with lo in the
// least significant LO_W bits.
//
// Contents:
//   LO_W, HI_W, PACK_W  default field widths and total word width
//   pack_t              packed word type
//   lo_of / hi_of       extract a field from a packed word
//   pack                build a packed word from its two fields
// ---------------------------------------------------------------------------
package packed_bus_pkg;

    localparam int LO_W   = 8;
    localparam int HI_W   = 4;
    localparam int PACK_W = LO_W + HI_W;

    typedef logic [PACK_W-1:0] pack_t;

    // Low field: feeds consumer 1 on the receive side.
    function automatic logic [LO_W-1:0] lo_of(input pack_t word);
        return word[LO_W-1:0];
    endfunction

    // High field: feeds consumer 2 on the receive side.
    function automatic logic [HI_W-1:0] hi_of(input pack_t word);
        return word[PACK_W-1:LO_W];
    endfunction

    // Inverse of lo_of/hi_of, used by the transmit side.
    function automatic pack_t pack(input logic [HI_W-1:0] hi, input logic [LO_W-1:0] lo);
        return {hi, lo};
    endfunction

endpackage : packed_bus_pkg

// File: rtl/packed_sync_fifo.sv
// ---------------------------------------------------------------------------
// packed_sync_fifo
//
// Single-clock FIFO holding whole packed words. The head entry is presented
// combinationally from storage, so a word written at one edge is readable in
// the following cycle. There is no write-to-read bypass: a push into an empty
// FIFO only becomes visible after the edge that stores it.
//
// Parameters:
//   WIDTH  bits per entry
//   DEPTH  number of entries, power of two and at least 2
//
// Ports:
//   clk_i    rising-edge clock
//   rst_ni   asynchronous active-low reset; empties the FIFO and clears storage
//   push_i   write data_i at the tail (ignored while full)
//   data_i   word to write
//   pop_i    discard the head entry (ignored while empty)
//   head_o   oldest stored word
//   full_o   all DEPTH entries occupied
//   empty_o  no entries occupied
//   level_o  number of entries occupied
// ---------------------------------------------------------------------------
module packed_sync_fifo
    import packed_bus_pkg::*;
#(
    parameter  int WIDTH = PACK_W,
    parameter  int DEPTH = 2,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [LVL_W-1:0] level_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [LVL_W-1:0] count_q, count_d;

    logic pushOk;
    logic popOk;

    // Pointer advance with explicit wrap. DEPTH is a power of two so the
    // natural rollover would also work, but the explicit compare keeps the
    // intent obvious and stays correct if that restriction is ever relaxed.
    function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] ptr);
        if (ptr == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return ptr + 1'b1;
    endfunction

    // Status flags come straight from the occupancy counter so full/empty
    // are unambiguous even when the two pointers are equal.
    assign full_o  = (count_q == LVL_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign level_o = count_q;
    assign head_o  = mem_q[rdPtr_q];

    // Guard the requests internally so a careless caller can never overrun
    // or underrun the storage.
    assign pushOk = push_i && !full_o;
    assign popOk  = pop_i && !empty_o;

    // Next-state for pointers and occupancy. A simultaneous push and pop
    // advances both pointers and leaves the count alone.
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (pushOk) begin
            wrPtr_d = nextPtr(wrPtr_q);
        end
        if (popOk) begin
            rdPtr_d = nextPtr(rdPtr_q);
        end
        case ({pushOk, popOk})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Control state. Reset is asynchronous so an in-flight transfer is
    // abandoned the moment rst_ni falls.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    // Storage. Entries are cleared on reset so the head reads as zero while
    // the FIFO is empty after reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (pushOk) begin
            mem_q[wrPtr_q] <= data_i;
        end
    end

endmodule : packed_sync_fifo

// File: rtl/packed_word_unpacker.sv
// ---------------------------------------------------------------------------
// packed_word_unpacker
//
// Receive end of the packed bus. Incoming {hi, lo} words are buffered in a
// small FIFO; the head word is then forked into two independent valid/ready
// streams, out1 carrying the lo field and out2 the hi field. Each consumer
// sees every word exactly once. A per-stream "taken" flag remembers that a
// consumer already accepted its half of the head word, so the faster
// consumer stalls with valid low until the slower one catches up, and only
// then is the head popped.
//
// Parameters:
//   LO_W   width of the low field / out1
//   HI_W   width of the high field / out2
//   DEPTH  FIFO entries, power of two and at least 2
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   in_valid    producer has a packed word on in_data
//   in_ready    a word can be accepted this cycle (FIFO not full)
//   in_data     packed word {hi, lo}
//   out1_valid  low field of the head word is available
//   out1_ready  consumer 1 accepts
//   out1        low field of the head word
//   out2_valid  high field of the head word is available
//   out2_ready  consumer 2 accepts
//   out2        high field of the head word
//   level       number of words currently stored
// ---------------------------------------------------------------------------
module packed_word_unpacker #(
    parameter int LO_W  = packed_bus_pkg::LO_W,
    parameter int HI_W  = packed_bus_pkg::HI_W,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [HI_W+LO_W-1:0]       in_data,
    output logic                       out1_valid,
    input  logic                       out1_ready,
    output logic [LO_W-1:0]            out1,
    output logic                       out2_valid,
    input  logic                       out2_ready,
    output logic [HI_W-1:0]            out2,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    import packed_bus_pkg::*;

    localparam int WORD_W = HI_W + LO_W;
    localparam int LVL_W  = $clog2(DEPTH + 1);

    logic [WORD_W-1:0] headWord;
    logic              fifoFull;
    logic              fifoEmpty;
    logic              push;
    logic              pop;
    logic              fire1;
    logic              fire2;
    logic              taken1_q, taken1_d;
    logic              taken2_q, taken2_d;

    // Accept only on registered FIFO state: no bypass when full, even if
    // the head is leaving in the same cycle. This keeps in_ready free of any
    // dependency on the output-side readies.
    assign in_ready = !fifoFull;
    assign push     = in_valid && in_ready;

    packed_sync_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .push_i  (push),
        .data_i  (in_data),
        .pop_i   (pop),
        .head_o  (headWord),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty),
        .level_o (level)
    );

    // Split the head word. Both fields always come from the same head entry
    // so a word cannot be torn between the two consumers. The package helpers
    // are used when the widths match the shared bus layout; other widths
    // fall back to plain slicing of the same layout.
    generate
        if (LO_W == packed_bus_pkg::LO_W && HI_W == packed_bus_pkg::HI_W) begin : g_pkgSplit
            assign out1 = lo_of(pack_t'(headWord));
            assign out2 = hi_of(pack_t'(headWord));
        end else begin : g_sliceSplit
            assign out1 = headWord[LO_W-1:0];
            assign out2 = headWord[WORD_W-1:LO_W];
        end
    endgenerate

    // A stream is offered only while its half of the head has not been
    // taken yet, which is what guarantees exactly-once delivery per consumer.
    assign out1_valid = !fifoEmpty && !taken1_q;
    assign out2_valid = !fifoEmpty && !taken2_q;
    assign fire1      = out1_valid && out1_ready;
    assign fire2      = out2_valid && out2_ready;

    // The head leaves once both halves are accounted for, counting a half
    // that is being accepted right now as well as one taken earlier.
    assign pop = (taken1_q || fire1) && (taken2_q || fire2);

    // Taken-flag next state: cleared on pop so the new head starts fresh,
    // otherwise sticky once its stream fires.
    always_comb begin
        taken1_d = taken1_q;
        taken2_d = taken2_q;
        if (pop) begin
            taken1_d = 1'b0;
            taken2_d = 1'b0;
        end else begin
            taken1_d = taken1_q || fire1;
            taken2_d = taken2_q || fire2;
        end
    end

    // Taken-flag registers. Async reset discards any half-delivered word
    // together with the FIFO contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            taken1_q <= 1'b0;
            taken2_q <= 1'b0;
        end else begin
            taken1_q <= taken1_d;
            taken2_q <= taken2_d;
        end
    end

    // LVL_W is only used to document the level width; tie it to the port so
    // a mismatch between the two shows up at elaboration.
    logic [LVL_W-1:0] levelShadow;
    assign levelShadow = level;

    logic unusedSignals;
    assign unusedSignals = ^levelShadow;

endmodule : packed_word_unpacker

// File: tb/tb_packed_word_unpacker.sv
// ---------------------------------------------------------------------------
// tb_packed_word_unpacker
//
// Self-checking bench for packed_word_unpacker with default parameters
// (LO_W=8, HI_W=4, DEPTH=2). Words handed to the DUT are recorded in two
// expectation queues (lo and hi fields); a monitor pops and compares every
// time a stream fires. Directed checks cover reset, latency, stalling, full
// behaviour, wrap-around and mid-stream reset; a randomised phase exercises
// independent ready toggling over 1000 words.
// ---------------------------------------------------------------------------
module tb_packed_word_unpacker;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] in_data;
    logic        out1_valid;
    logic        out1_ready;
    logic [7:0]  out1;
    logic        out2_valid;
    logic        out2_ready;
    logic [3:0]  out2;
    logic [1:0]  level;

    int passCount  = 0;
    int checkCount = 0;

    logic [7:0] exp1 [$];
    logic [3:0] exp2 [$];
    logic [7:0] mon1;
    logic [3:0] mon2;

    logic       trackMax = 1'b0;
    logic [1:0] maxLevel = '0;
    logic       randDone = 1'b0;

    packed_word_unpacker #(
        .LO_W  (8),
        .HI_W  (4),
        .DEPTH (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out1       (out1),
        .out2_valid (out2_valid),
        .out2_ready (out2_ready),
        .out2       (out2),
        .level      (level)
    );

    // 10 ns clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One comparison: counted, and reported only on failure.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 'h%0h, required 'h%0h", name, actual, expected);
        end
    endtask

    // Present one word and hold it until accepted. The expectation is queued
    // at the falling edge before the accepting rising edge, i.e. exactly when
    // the handshake is known to complete. Returns #1 after that rising edge.
    task automatic applyStimulus(input logic [11:0] data);
        int waitCycles = 0;
        in_valid = 1'b1;
        in_data  = data;
        @(negedge clk);
        while (!in_ready && waitCycles < 200) begin
            @(negedge clk);
            waitCycles++;
        end
        if (!in_ready) begin
            checkCount++;
            $display("[TB] FAIL push_timeout: in_ready stayed 0, required 1 for word 'h%0h", data);
            in_valid = 1'b0;
        end else begin
            exp1.push_back(data[7:0]);
            exp2.push_back(data[11:8]);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
    endtask

    // Move to the usual drive point: #1 after a rising edge.
    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: whenever a stream will fire at the coming edge,
    // its data must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out1_valid && out1_ready) begin
                if (exp1.size() == 0) begin
                    checkCount++;
                    $display("[TB] FAIL out1_unexpected: got 'h%0h, required no transfer", out1);
                end else begin
                    mon1 = exp1.pop_front();
                    checkOutput("out1_data", {24'd0, out1}, {24'd0, mon1});
                end
            end
            if (out2_valid && out2_ready) begin
                if (exp2.size() == 0) begin
                    checkCount++;
                    $display("[TB] FAIL out2_unexpected: got 'h%0h, required no transfer", out2);
                end else begin
                    mon2 = exp2.pop_front();
                    checkOutput("out2_data", {28'd0, out2}, {28'd0, mon2});
                end
            end
            if (trackMax && level > maxLevel) begin
                maxLevel = level;
            end
        end
    end

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        out1_ready = 1'b0;
        out2_ready = 1'b0;

        // ---------------- reset state ----------------
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rst_in_ready",   32'(in_ready),   32'd1);
        checkOutput("rst_out1_valid", 32'(out1_valid), 32'd0);
        checkOutput("rst_out2_valid", 32'(out2_valid), 32'd0);
        checkOutput("rst_out1",       32'(out1),       32'd0);
        checkOutput("rst_out2",       32'(out2),       32'd0);
        checkOutput("rst_level",      32'(level),      32'd0);
        nextCycle();

        // ---------------- single word, both ready ----------------
        out1_ready = 1'b1;
        out2_ready = 1'b1;
        applyStimulus(12'hA5C);
        @(negedge clk);
        checkOutput("a5c_out1_valid", 32'(out1_valid), 32'd1);
        checkOutput("a5c_out2_valid", 32'(out2_valid), 32'd1);
        checkOutput("a5c_out1",       32'(out1),       32'h5C);
        checkOutput("a5c_out2",       32'(out2),       32'hA);
        checkOutput("a5c_level",      32'(level),      32'd1);
        nextCycle();
        @(negedge clk);
        checkOutput("a5c_level_after", 32'(level),      32'd0);
        checkOutput("a5c_valid_after", 32'(out1_valid), 32'd0);
        nextCycle();

        // ---------------- consumer 2 stalls ----------------
        out1_ready = 1'b1;
        out2_ready = 1'b0;
        applyStimulus(12'h3F1);
        @(negedge clk);
        checkOutput("3f1_out1_valid_first", 32'(out1_valid), 32'd1);
        for (int c = 0; c < 2; c++) begin
            nextCycle();
            @(negedge clk);
            checkOutput("3f1_out1_valid_stall", 32'(out1_valid), 32'd0);
            checkOutput("3f1_out2_valid_stall", 32'(out2_valid), 32'd1);
            checkOutput("3f1_out2_stall",       32'(out2),       32'h3);
            checkOutput("3f1_level_stall",      32'(level),      32'd1);
        end
        nextCycle();
        out2_ready = 1'b1;
        nextCycle();
        @(negedge clk);
        checkOutput("3f1_level_after", 32'(level), 32'd0);
        nextCycle();

        // ---------------- fill to full, hold extra word ----------------
        out1_ready = 1'b0;
        out2_ready = 1'b0;
        applyStimulus(12'h111);
        applyStimulus(12'h222);
        @(negedge clk);
        checkOutput("full_level",    32'(level),    32'd2);
        checkOutput("full_in_ready", 32'(in_ready), 32'd0);
        nextCycle();
        in_valid = 1'b1;
        in_data  = 12'h333;
        repeat (2) nextCycle();
        @(negedge clk);
        checkOutput("full_hold_level", 32'(level), 32'd2);
        checkOutput("full_head_out1",  32'(out1),  32'h11);
        nextCycle();
        in_valid   = 1'b0;
        out1_ready = 1'b1;
        out2_ready = 1'b1;
        repeat (3) nextCycle();
        @(negedge clk);
        checkOutput("full_drain_level", 32'(level), 32'd0);
        nextCycle();

        // ---------------- continuous stream with wrap-around ----------------
        maxLevel = '0;
        trackMax = 1'b1;
        for (int w = 0; w < 8; w++) begin
            applyStimulus(12'(w));
        end
        repeat (3) nextCycle();
        trackMax = 1'b0;
        checkOutput("stream_max_level", 32'(maxLevel), 32'd1);
        checkOutput("stream_drained",   32'(exp1.size() + exp2.size()), 32'd0);

        // ---------------- reset mid-stream ----------------
        out1_ready = 1'b0;
        out2_ready = 1'b0;
        applyStimulus(12'h4B7);
        applyStimulus(12'h5C8);
        out1_ready = 1'b1;
        nextCycle();
        out1_ready = 1'b0;
        @(negedge clk);
        checkOutput("pre_rst_level",      32'(level),      32'd2);
        checkOutput("pre_rst_out1_valid", 32'(out1_valid), 32'd0);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_out1_valid", 32'(out1_valid), 32'd0);
        checkOutput("mid_rst_out2_valid", 32'(out2_valid), 32'd0);
        checkOutput("mid_rst_level",      32'(level),      32'd0);
        checkOutput("mid_rst_in_ready",   32'(in_ready),   32'd1);
        exp1.delete();
        exp2.delete();
        nextCycle();
        rst_n      = 1'b1;
        out1_ready = 1'b1;
        out2_ready = 1'b1;
        nextCycle();
        applyStimulus(12'hFFF);
        @(negedge clk);
        checkOutput("fff_out1", 32'(out1), 32'hFF);
        checkOutput("fff_out2", 32'(out2), 32'hF);
        repeat (2) nextCycle();

        // ---------------- random ready toggling, 1000 words ----------------
        fork
            begin
                int waitCycles = 0;
                for (int w = 0; w < 1000; w++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        nextCycle();
                    end
                    applyStimulus(12'($urandom));
                end
                while ((exp1.size() != 0 || exp2.size() != 0) && waitCycles < 5000) begin
                    nextCycle();
                    waitCycles++;
                end
                randDone = 1'b1;
            end
            begin
                while (!randDone) begin
                    nextCycle();
                    out1_ready = 1'($urandom_range(0, 1));
                    out2_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        checkOutput("random_drained", 32'(exp1.size() + exp2.size()), 32'd0);
        out1_ready = 1'b0;
        out2_ready = 1'b0;
        nextCycle();
        @(negedge clk);
        checkOutput("random_final_level", 32'(level), 32'd0);

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule : tb_packed_word_unpacker
